// File: rtl/controle_multiciclo_if.sv
// Signal bundle between the nRISC multicycle control unit and its datapath/memory.
// The master side is the control unit; the slave side is the datapath.
interface controle_multiciclo_if #(
  parameter int LARG_CONT = 8
);
  logic [2:0]           opcode;
  logic                 zero;
  logic                 mem_pronto;
  logic                 pc_escreve;
  logic [1:0]           sel_pc;
  logic                 ir_escreve;
  logic                 mem_le;
  logic                 mem_escreve;
  logic                 reg_escreve;
  logic                 sel_wb;
  logic                 sel_b;
  logic [1:0]           sel_ula;
  logic [2:0]           estado;
  logic                 parado;
  logic [LARG_CONT-1:0] instr_concluidas;

  modport master (
    input  opcode, zero, mem_pronto,
    output pc_escreve, sel_pc, ir_escreve, mem_le, mem_escreve, reg_escreve,
           sel_wb, sel_b, sel_ula, estado, parado, instr_concluidas
  );

  modport slave (
    output opcode, zero, mem_pronto,
    input  pc_escreve, sel_pc, ir_escreve, mem_le, mem_escreve, reg_escreve,
           sel_wb, sel_b, sel_ula, estado, parado, instr_concluidas
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the 8-bit nRISC: fetch/decode/execute/memory/write-back
// sequencing, memory-ready handshake and a wrapping retired-instruction counter.
module controle_multiciclo #(
  parameter int LARG_CONT = 8
) (
  input logic                  clock,
  input logic                  reset,
  controle_multiciclo_if.master bus
);
  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5,
    OP_JMP  = 3'd6,
    OP_HALT = 3'd7
  } op_t;

  estado_t              estado_q, estado_d;
  logic [LARG_CONT-1:0] cont_q;
  logic                 retira;
  op_t                  op;

  assign op                   = op_t'(bus.opcode);
  assign bus.estado           = estado_q;
  assign bus.instr_concluidas = cont_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= BUSCA;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      if (retira) cont_q <= cont_q + LARG_CONT'(1);
    end
  end

  always_comb begin
    estado_d        = estado_q;
    retira          = 1'b0;
    bus.pc_escreve  = 1'b0;
    bus.sel_pc      = 2'b00;
    bus.ir_escreve  = 1'b0;
    bus.mem_le      = 1'b0;
    bus.mem_escreve = 1'b0;
    bus.reg_escreve = 1'b0;
    bus.sel_wb      = 1'b0;
    bus.sel_b       = 1'b0;
    bus.sel_ula     = 2'b00;
    bus.parado      = 1'b0;

    case (estado_q)
      BUSCA: begin
        bus.mem_le = 1'b1;
        if (bus.mem_pronto) begin
          bus.ir_escreve = 1'b1;
          bus.pc_escreve = 1'b1;
          estado_d       = DECODIFICA;
        end
      end
      DECODIFICA: estado_d = (op == OP_HALT) ? PARADO : EXECUTA;
      EXECUTA: begin
        estado_d = BUSCA;
        case (op)
          OP_ADD:  estado_d = ESCRITA;
          OP_SUB: begin
            bus.sel_ula = 2'b01;
            estado_d    = ESCRITA;
          end
          OP_ADDI: begin
            bus.sel_b = 1'b1;
            estado_d  = ESCRITA;
          end
          OP_LW, OP_SW: begin
            bus.sel_b = 1'b1;
            estado_d  = MEMORIA;
          end
          OP_BEQ: begin
            bus.sel_ula = 2'b01;
            if (bus.zero) begin
              bus.pc_escreve = 1'b1;
              bus.sel_pc     = 2'b01;
            end
            retira = 1'b1;
          end
          OP_JMP: begin
            bus.pc_escreve = 1'b1;
            bus.sel_pc     = 2'b10;
            retira         = 1'b1;
          end
          default: ;
        endcase
      end
      MEMORIA: begin
        // An opcode that is neither LW nor SW cannot legally reach here; abandon it.
        if (op == OP_LW) begin
          bus.mem_le = 1'b1;
          if (bus.mem_pronto) estado_d = ESCRITA;
        end else if (op == OP_SW) begin
          bus.mem_escreve = 1'b1;
          if (bus.mem_pronto) begin
            estado_d = BUSCA;
            retira   = 1'b1;
          end
        end else begin
          estado_d = BUSCA;
        end
      end
      ESCRITA: begin
        bus.reg_escreve = 1'b1;
        bus.sel_wb      = (op == OP_LW);
        estado_d        = BUSCA;
        retira          = 1'b1;
      end
      PARADO:  bus.parado = 1'b1;
      default: estado_d = BUSCA;
    endcase

    if (reset) begin
      retira          = 1'b0;
      bus.pc_escreve  = 1'b0;
      bus.ir_escreve  = 1'b0;
      bus.mem_le      = 1'b0;
      bus.mem_escreve = 1'b0;
      bus.reg_escreve = 1'b0;
      bus.parado      = 1'b0;
    end
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control unit for the 8-bit nRISC datapath.
- Sequences fetch, decode, execute, memory and write-back.
- Drives the datapath strobes and multiplexer selects, including the select that routes the 2-bit immediate, zero-extended to 3 bits, into ALU operand B.
- Waits on a memory-ready handshake and counts retired instructions.

Parameters:
- LARG_CONT, 8, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  3  instruction register bits [7:5]; valid from DECODIFICA onward.
- zero  input  1  ALU zero flag, combinational from the current ALU operation.
- mem_pronto  input  1  memory completes the current read or write this cycle.
- pc_escreve  output  1  PC load enable.
- sel_pc  output  2  PC source: 00 = PC+1, 01 = PC + extended immediate, 10 = jump target.
- ir_escreve  output  1  instruction register load enable.
- mem_le  output  1  memory read request.
- mem_escreve  output  1  memory write request.
- reg_escreve  output  1  register file write enable.
- sel_wb  output  1  write-back source: 0 = ALU result register, 1 = memory data.
- sel_b  output  1  ALU operand B: 0 = register, 1 = zero-extended immediate.
- sel_ula  output  2  ALU operation: 00 = ADD, 01 = SUB, others reserved.
- estado  output  3  current state encoding.
- parado  output  1  processor halted.
- instr_concluidas  output  LARG_CONT  retired-instruction count; wraps.

Behaviour:
- State register and counter are registered. All other outputs are combinational from estado, opcode, zero and mem_pronto.
- Every strobe not listed for a state is 0. Every select not listed for a state is 0.
- State encoding: BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, PARADO=5. Codes 6 and 7 go to BUSCA on the next edge with all strobes 0.
- Reset, taking priority over everything:
  - Next state is BUSCA; instr_concluidas is 0.
  - While reset is high, all strobes are forced to 0 and parado is 0.
  - Reset mid-instruction abandons the instruction; the count does not increment.
- Opcode map: 000 ADD, 001 SUB, 010 ADDI, 011 LW, 100 SW, 101 BEQ, 110 JMP, 111 HALT.
- BUSCA:
  - mem_le=1.
  - If mem_pronto: ir_escreve=1, pc_escreve=1, sel_pc=00, next DECODIFICA.
  - Otherwise stay in BUSCA with no PC or IR write. There is no timeout.
- DECODIFICA:
  - No strobes.
  - opcode 111 -> PARADO; otherwise -> EXECUTA.
- EXECUTA:
  - ADD: sel_ula=00, sel_b=0 -> ESCRITA.
  - SUB: sel_ula=01, sel_b=0 -> ESCRITA.
  - ADDI: sel_ula=00, sel_b=1 -> ESCRITA.
  - LW/SW: sel_ula=00, sel_b=1 (address compute) -> MEMORIA.
  - BEQ: sel_ula=01, sel_b=0. If zero: pc_escreve=1, sel_pc=01. Taken or not -> BUSCA; the instruction retires.
  - JMP: pc_escreve=1, sel_pc=10 -> BUSCA; the instruction retires.
- MEMORIA:
  - LW: mem_le=1. SW: mem_escreve=1.
  - Stay while mem_pronto=0.
  - On mem_pronto: LW -> ESCRITA; SW -> BUSCA and retires.
  - mem_le and mem_escreve are never both 1.
- ESCRITA:
  - reg_escreve=1 for exactly one cycle.
  - sel_wb=1 for LW, 0 otherwise.
  - -> BUSCA; the instruction retires.
- Retire: instr_concluidas increments by 1 on the edge leaving the retiring state. It wraps from 2^LARG_CONT-1 to 0. HALT does not count as retired.
- PARADO: parado=1, all strobes 0, stays until reset.
- Cycle counts with mem_pronto=1 throughout:
  - ADD/SUB/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW, BEQ, JMP: 4, 3, 3 cycles.
- Each memory wait cycle adds 1 cycle.

Test Plan:
- Reset with mem_pronto=1, opcode=000 for 4 cycles -> estado sequence 0,1,2,4. reg_escreve=1 only in the 4th cycle. instr_concluidas=1 after the 4th edge.
- LW (011) with mem_pronto low for 2 cycles in BUSCA and 3 cycles in MEMORIA -> 10 cycles total. mem_le held high throughout both waits. sel_wb=1 and reg_escreve=1 in ESCRITA. Count +1.
- BEQ (101) with zero=1 -> pc_escreve=1, sel_pc=01 in EXECUTA. With zero=0 -> pc_escreve=0 in EXECUTA. Both cases return to BUSCA after 3 cycles and count +1.
- SW (100) then HALT (111) -> mem_escreve=1 only in MEMORIA. After HALT decode: estado=5, parado=1, all strobes 0 for 20 cycles, count unchanged.
- Assert reset during MEMORIA of an LW -> next estado=0. Strobes are 0 during reset. Count unchanged and no reg_escreve pulse. Reset during PARADO clears parado.
- Set LARG_CONT=2 and retire 5 ADDI (010) -> count runs 1,2,3,0,1. sel_b=1 in each EXECUTA.
